// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared DES tables (IP, FP, E, P, PC1, PC2, S-boxes, key
//                shift schedule), core state type and permutation helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package des_pkg;

    localparam int ROUNDS_TOTAL = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Tables use DES numbering: entry value 1 is the MSB of the source word.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Eight boxes of 4 rows x 16 columns, flattened box-major.
    localparam int SBOX_T [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    function automatic logic [63:0] ip_perm(input logic [63:0] d);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] d);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] r);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = r[5'(32 - E_T[i])];
        return o;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] s);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - P_T[i])];
        return o;
    endfunction

    // Row comes from the outer bits of each 6-bit group, column from the inner four.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  six;
        int          idx;
        o = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            idx = b * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
            o[5'(31 - 4 * b) -: 4] = 4'(SBOX_T[idx]);
        end
        return o;
    endfunction

    // Subkey n (1..16): PC1, rotate C and D by the cumulative shift, then PC2.
    function automatic logic [47:0] subkey(input logic [63:0] key, input logic [4:0] n);
        logic [55:0] cd;
        logic [55:0] cc;
        logic [55:0] dd;
        logic [55:0] rot;
        logic [47:0] k;
        int          s;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
        s = 0;
        for (int i = 0; i < 16; i++) if (i < int'(n)) s += SHIFT_T[i];
        cc  = {cd[55:28], cd[55:28]};
        dd  = {cd[27:0], cd[27:0]};
        rot = {cc[6'(55 - s) -: 28], dd[6'(55 - s) -: 28]};
        for (int i = 0; i < 48; i++) k[6'(47 - i)] = rot[6'(56 - PC2_T[i])];
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_round_unit.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_unit
//  Description : One combinational DES Feistel round:
//                L' = R, R' = L ^ P(S(E(R) ^ K)).
//  Revision    : 1.0  initial release
// ============================================================================
module des_round_unit
    import des_pkg::*;
(
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [47:0] subkey_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o
);

    logic [31:0] w_f;

    assign w_f = p_perm(sbox_sub(e_expand(r_i) ^ subkey_i));
    assign l_o = r_i;
    assign r_o = l_i ^ w_f;

endmodule
`default_nettype wire

// File: rtl/tdes_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : tdes_iter_core
//  Description : Iterative DES / Triple-DES (EDE) block cipher core with a
//                valid/ready handshake and ROUNDS_PER_CYCLE unrolled rounds.
//                Define TDES_EN for three-pass EDE; otherwise single DES
//                with key1 only.
//  Revision    : 1.0  initial release
// ============================================================================
module tdes_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_data,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam int RPC = ROUNDS_PER_CYCLE;

`ifdef TDES_EN
    localparam logic [1:0] c_LAST_PASS = 2'd2;
`else
    localparam logic [1:0] c_LAST_PASS = 2'd0;
`endif

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
        $error("tdes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_e      state_q;
    logic [31:0] l_q;
    logic [31:0] r_q;
    logic [3:0]  rnd_q;
    logic [1:0]  pass_q;
    logic        dec_q;
    logic [63:0] key1_q;
`ifdef TDES_EN
    logic [63:0] key2_q;
    logic [63:0] key3_q;
`endif
    logic [63:0] out_data_q;
    logic        out_valid_q;

    logic        w_pass_dec;
    logic [63:0] w_pass_key;
    logic        w_pass_end;
    logic [31:0] w_l [RPC+1];
    logic [31:0] w_r [RPC+1];

`ifdef TDES_EN
    // Encrypt runs E(k1) D(k2) E(k3); decrypt runs D(k3) E(k2) D(k1).
    always_comb begin
        w_pass_dec = dec_q ^ (pass_q == 2'd1);
        case (pass_q)
            2'd0:    w_pass_key = dec_q ? key3_q : key1_q;
            2'd1:    w_pass_key = key2_q;
            default: w_pass_key = dec_q ? key1_q : key3_q;
        endcase
    end
`else
    logic w_unused_keys;
    assign w_unused_keys = ^{key2, key3};
    assign w_pass_dec    = dec_q;
    assign w_pass_key    = key1_q;
`endif

    assign w_l[0]     = l_q;
    assign w_r[0]     = r_q;
    assign w_pass_end = (5'(rnd_q) + 5'(RPC)) == 5'(ROUNDS_TOTAL);

    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [4:0]  w_idx;
        logic [4:0]  w_num;
        logic [47:0] w_key;
        assign w_idx = 5'(rnd_q) + 5'(j);
        assign w_num = w_pass_dec ? (5'(ROUNDS_TOTAL) - w_idx) : (w_idx + 5'd1);
        assign w_key = subkey(w_pass_key, w_num);
        des_round_unit u_round (
            .l_i      (w_l[j]),
            .r_i      (w_r[j]),
            .subkey_i (w_key),
            .l_o      (w_l[j+1]),
            .r_o      (w_r[j+1])
        );
    end

    // Control FSM and datapath registers: accept, iterate passes, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            rnd_q       <= '0;
            pass_q      <= '0;
            dec_q       <= 1'b0;
            key1_q      <= '0;
`ifdef TDES_EN
            key2_q      <= '0;
            key3_q      <= '0;
`endif
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dec_q      <= in_decrypt;
                        key1_q     <= key1;
`ifdef TDES_EN
                        key2_q     <= key2;
                        key3_q     <= key3;
`endif
                        {l_q, r_q} <= ip_perm(in_data);
                        rnd_q      <= '0;
                        pass_q     <= '0;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    rnd_q <= rnd_q + 4'(RPC);
                    if (w_pass_end && pass_q == c_LAST_PASS) begin
                        out_data_q  <= fp_perm({w_r[RPC], w_l[RPC]});
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (w_pass_end) begin
                        // IP/FP cancel between passes: feed {R16, L16} straight in.
                        l_q    <= w_r[RPC];
                        r_q    <= w_l[RPC];
                        pass_q <= pass_q + 2'd1;
                    end else begin
                        l_q <= w_l[RPC];
                        r_q <= w_r[RPC];
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tdes_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdes_iter_core
//  Description : Directed self-checking bench for tdes_iter_core (one- and
//                four-rounds-per-cycle instances) with a result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tdes_iter_core;

`ifdef TDES_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2 = 64'h8787878787878787;
    localparam logic [63:0] CT2 = 64'h0000000000000000;
`ifdef TDES_EN
    localparam logic [63:0] KX2 = K1;
    localparam logic [63:0] KX3 = K1;
`else
    localparam logic [63:0] KX2 = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] KX3 = 64'h0F1E2D3C4B5A6978;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_decrypt = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] key1 = '0;
    logic [63:0] key2 = '0;
    logic [63:0] key3 = '0;
    logic        sel = 1'b0;

    logic        rdy_a, ov_a, busy_a, rdy_b, ov_b, busy_b;
    logic [63:0] od_a, od_b;
    logic        in_ready_m, out_valid_m, busy_m;
    logic [63:0] out_data_m;

    int          ntests = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [63:0] last_res = '0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tdes_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(rdy_a),
        .in_decrypt(in_decrypt), .in_data(in_data), .key1(key1), .key2(key2), .key3(key3),
        .out_valid(ov_a), .out_ready(out_ready & ~sel), .out_data(od_a), .busy(busy_a)
    );

    tdes_iter_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(rdy_b),
        .in_decrypt(in_decrypt), .in_data(in_data), .key1(key1), .key2(key2), .key3(key3),
        .out_valid(ov_b), .out_ready(out_ready & sel), .out_data(od_b), .busy(busy_b)
    );

    assign in_ready_m  = sel ? rdy_b  : rdy_a;
    assign out_valid_m = sel ? ov_b   : ov_a;
    assign busy_m      = sel ? busy_b : busy_a;
    assign out_data_m  = sel ? od_b   : od_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge with the selected core idle.
    task automatic send(input logic [63:0] d, input logic dec,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] expv);
        chk("in_ready_before_accept", 64'(in_ready_m), 64'd1);
        in_data = d; in_decrypt = dec; key1 = a; key2 = b; key3 = c; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        exp_q.push_back(expv);
        in_valid   = 1'b0;
        in_data    = {$urandom, $urandom};
        key1       = {$urandom, $urandom};
        key2       = {$urandom, $urandom};
        key3       = {$urandom, $urandom};
        in_decrypt = ~dec;
        @(negedge clk);
        chk("busy_after_accept", 64'(busy_m), 64'd1);
        chk("in_ready_after_accept", 64'(in_ready_m), 64'd0);
        chk("out_data_held_in_round", out_data_m, last_res);
    endtask

    task automatic collect(input string tag, input int hold);
        int          n;
        int          rpc;
        logic [63:0] e;
        n   = 0;
        rpc = sel ? 4 : 1;
        while (out_valid_m !== 1'b1 && n < 200) begin
            in_valid = n[0];
            in_data  = {$urandom, $urandom};
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_valid"}, 64'(out_valid_m), 64'd1);
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(16 * P / rpc));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        chk({tag, "_data"}, out_data_m, e);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~i[0];
            in_data  = {$urandom, $urandom};
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid_m), 64'd1);
            chk({tag, "_hold_data"}, out_data_m, e);
            chk({tag, "_hold_in_ready"}, 64'(in_ready_m), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drain_valid"}, 64'(out_valid_m), 64'd0);
        chk({tag, "_drain_in_ready"}, 64'(in_ready_m), 64'd1);
        chk({tag, "_drain_busy"}, 64'(busy_m), 64'd0);
        chk({tag, "_idle_data"}, out_data_m, e);
        last_res = e;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready_m), 64'd1);
        chk("reset_out_valid", 64'(out_valid_m), 64'd0);
        chk("reset_busy", 64'(busy_m), 64'd0);
        chk("reset_out_data", out_data_m, 64'd0);
        rst = 1'b0;

        send(PT, 1'b0, K1, K1, K1, CT);      collect("enc1", 0);
        send(CT, 1'b1, K1, K1, K1, PT);      collect("dec1", 5);
        send(PT2, 1'b0, K2, K2, K2, CT2);    collect("enc2", 0);
        send(CT2, 1'b1, K2, K2, K2, PT2);    collect("dec2", 1);
        send(PT, 1'b0, K1, KX2, KX3, CT);    collect("enc_keys23", 0);

        // Abort mid-block with reset, then restart on the first edge after release.
        send(PT, 1'b0, K1, K1, K1, CT);
        repeat (7) @(negedge clk);
        rst = 1'b1; #1;
        exp_q.delete();
        last_res = '0;
        chk("midrst_out_valid", 64'(out_valid_m), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_m), 64'd1);
        chk("midrst_busy", 64'(busy_m), 64'd0);
        chk("midrst_out_data", out_data_m, 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_valid", 64'(out_valid_m), 64'd0);
        end
        rst = 1'b0;
        send(PT, 1'b0, K1, K1, K1, CT);      collect("post_rst_enc", 0);

        sel = 1'b1;
        last_res = '0;
        send(PT, 1'b0, K1, K1, K1, CT);      collect("r4_enc", 2);
        send(CT, 1'b1, K1, K1, K1, PT);      collect("r4_dec", 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
